// File: rtl/motor_pwm_drive.sv
// Two-channel H-bridge PWM drive: soft-start ramp, dead-time coast on reversal, latched overcurrent fault.
// Inputs pass 2-flop synchronizers; bridge pins are registered from FSM state, PWM from next state.
module motor_pwm_drive #(
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 4096,
  parameter int DEADTIME = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_overcurrent_stop,
  input  logic                i_enable,
  input  logic                i_dir_left,
  input  logic                i_dir_right,
  input  logic [PWM_BITS-1:0] i_duty_target,
  output logic                o_pwm_left,
  output logic                o_pwm_right,
  output logic                o_in1_left,
  output logic                o_in2_left,
  output logic                o_in1_right,
  output logic                o_in2_right,
  output logic                o_fault
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DEAD, ST_FAULT} state_t;

  logic [3:0]          r_sync1, r_sync2;
  logic [PWM_BITS-1:0] r_cnt;
  logic [RW-1:0]       r_ramp_cnt;
  logic                r_fault;
  logic                w_oc, w_en, w_wrap, w_tick;
  logic [1:0]          w_dir, w_pwm, w_in1, w_in2, w_in_fault;

  assign w_oc   = r_sync2[0];
  assign w_en   = r_sync2[1];
  assign w_dir  = r_sync2[3:2];
  assign w_wrap = (r_cnt == {PWM_BITS{1'b1}});
  assign w_tick = (r_ramp_cnt == RW'(RAMP_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cnt      <= '0;
      r_ramp_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_sync1    <= {i_dir_right, i_dir_left, i_enable, i_overcurrent_stop};
      r_sync2    <= r_sync1;
      r_cnt      <= r_cnt + 1'b1;
      r_ramp_cnt <= w_tick ? '0 : r_ramp_cnt + 1'b1;
      r_fault    <= |w_in_fault;
    end
  end

  genvar g;
  for (g = 0; g < 2; g++) begin : g_ch
    state_t              r_state, w_state_nxt;
    logic                r_dir_app, w_dir_app_nxt;
    logic [DW-1:0]       r_dead, w_dead_nxt;
    logic [PWM_BITS-1:0] r_duty, w_duty_nxt, r_cmp;
    logic                r_pwm, r_in1, r_in2;

    always_comb begin
      w_state_nxt   = r_state;
      w_dir_app_nxt = r_dir_app;
      w_dead_nxt    = '0;
      w_duty_nxt    = r_duty;
      if (w_oc) begin
        w_state_nxt = ST_FAULT;
        w_duty_nxt  = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_duty_nxt = '0;
            if (w_en) begin
              w_state_nxt   = ST_DRIVE;
              w_dir_app_nxt = w_dir[g];
            end
          end
          ST_DRIVE: begin
            if (!w_en) begin
              w_state_nxt = ST_IDLE;
              w_duty_nxt  = '0;
            end else if (w_dir[g] != r_dir_app) begin
              w_state_nxt = ST_DEAD;
              w_duty_nxt  = '0;
            end else if (w_tick) begin
              if (r_duty < i_duty_target)      w_duty_nxt = r_duty + 1'b1;
              else if (r_duty > i_duty_target) w_duty_nxt = r_duty - 1'b1;
            end
          end
          ST_DEAD: begin
            // Count runs to completion even if the switch flips back meanwhile.
            w_duty_nxt = '0;
            if (!w_en) begin
              w_state_nxt = ST_IDLE;
            end else if (r_dead == DW'(DEADTIME - 1)) begin
              w_state_nxt   = ST_DRIVE;
              w_dir_app_nxt = w_dir[g];
            end else begin
              w_dead_nxt = r_dead + 1'b1;
            end
          end
          ST_FAULT: begin
            w_duty_nxt = '0;
            if (!w_en) w_state_nxt = ST_IDLE;
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state   <= ST_IDLE;
        r_dir_app <= 1'b0;
        r_dead    <= '0;
        r_duty    <= '0;
        r_cmp     <= '0;
        r_pwm     <= 1'b0;
        r_in1     <= 1'b0;
        r_in2     <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_dir_app <= w_dir_app_nxt;
        r_dead    <= w_dead_nxt;
        r_duty    <= w_duty_nxt;
        if (w_wrap) r_cmp <= r_duty;
        // Gating on the next state drops PWM on the same edge the FSM leaves DRIVE.
        r_pwm     <= (w_state_nxt == ST_DRIVE) && (r_cnt < r_cmp);
        r_in1     <= (r_state == ST_DRIVE) && r_dir_app;
        r_in2     <= (r_state == ST_DRIVE) && !r_dir_app;
      end
    end

    assign w_pwm[g]      = r_pwm;
    assign w_in1[g]      = r_in1;
    assign w_in2[g]      = r_in2;
    assign w_in_fault[g] = (r_state == ST_FAULT);
  end

  assign o_pwm_left  = w_pwm[0];
  assign o_pwm_right = w_pwm[1];
  assign o_in1_left  = w_in1[0];
  assign o_in2_left  = w_in2[0];
  assign o_in1_right = w_in1[1];
  assign o_in2_right = w_in2[1];
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Scoreboard bench for motor_pwm_drive: stimulus queues expected outputs, a negedge monitor checks them.
module tb_motor_pwm_drive;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       oc = 1'b0, en = 1'b0, dl = 1'b0, dr = 1'b0;
  logic [3:0] duty = 4'd0;
  logic       pwm_l, pwm_r, in1_l, in2_l, in1_r, in2_r, fault;
  logic [6:0] outs;
  int         cyc = 0;
  int         n_run = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  motor_pwm_drive #(.PWM_BITS(4), .RAMP_DIV(4), .DEADTIME(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_overcurrent_stop(oc), .i_enable(en),
    .i_dir_left(dl), .i_dir_right(dr), .i_duty_target(duty),
    .o_pwm_left(pwm_l), .o_pwm_right(pwm_r), .o_in1_left(in1_l), .o_in2_left(in2_l),
    .o_in1_right(in1_r), .o_in2_right(in2_r), .o_fault(fault));

  // bit 6 fault, 5 pwm_r, 4 in1_r, 3 in2_r, 2 pwm_l, 1 in1_l, 0 in2_l
  assign outs = {fault, pwm_r, in1_r, in2_r, pwm_l, in1_l, in2_l};

  // kind 0: masked compare; 1/2/3: high count of one bit over 16 cycles ==, <=, >= val
  typedef struct {
    int           stamp;
    int           kind;
    logic [6:0]   exp;
    logic [6:0]   mask;
    int           bitsel;
    int           val;
    logic [127:0] nm;
  } exp_t;
  exp_t sb[$];

  task automatic expect_at(input int dly, input logic [6:0] e, input logic [6:0] m, input logic [127:0] nm);
    exp_t x;
    x.stamp = cyc + dly; x.kind = 0; x.exp = e; x.mask = m; x.bitsel = 0; x.val = 0; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic expect_win(input int dly, input int bitsel, input int kind, input int val, input logic [127:0] nm);
    exp_t x;
    x.stamp = cyc + dly; x.kind = kind; x.exp = '0; x.mask = '0; x.bitsel = bitsel; x.val = val; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    int   hc;
    bit   ok;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
        e = sb.pop_front();
        n_run++;
        if (e.stamp < cyc) begin
          n_fail++;
          $display("FAIL %0s: checked at cycle %0d, required cycle %0d", e.nm, cyc, e.stamp);
        end else if (e.kind == 0) begin
          if ((outs & e.mask) !== (e.exp & e.mask)) begin
            n_fail++;
            $display("FAIL %0s @%0d: outs=%b required=%b mask=%b", e.nm, cyc, outs, e.exp, e.mask);
          end
        end else begin
          hc = 0;
          for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (outs[e.bitsel] === 1'b1) hc++;
          end
          ok = (e.kind == 1) ? (hc == e.val) : (e.kind == 2) ? (hc <= e.val) : (hc >= e.val);
          if (!ok) begin
            n_fail++;
            $display("FAIL %0s @%0d: high count=%0d required %s %0d", e.nm, cyc, hc,
                     (e.kind == 1) ? "==" : (e.kind == 2) ? "<=" : ">=", e.val);
          end
        end
      end
    end
  end

  initial begin : stim
    // reset state
    tick(2);
    expect_at(0, 7'b0000000, 7'h7F, "reset_outs");
    tick(1);
    rst = 1'b0;
    tick(4);

    // soft start, both forward, duty 8
    dl = 1'b1; dr = 1'b1; duty = 4'd8; en = 1'b1;
    expect_at(3, 7'b0000000, 7'b0011011, "en_pre_pins");
    expect_at(4, 7'b0010010, 7'b0011011, "en_pins_fwd");
    expect_win(4, 2, 2, 5, "soft_start_low");
    expect_win(90, 2, 1, 8, "duty8_left");
    expect_win(110, 5, 1, 8, "duty8_right");
    tick(130);

    // reversal of left channel
    dl = 1'b0;
    expect_at(3, 7'b0000010, 7'b0000111, "rev_last_old");
    for (int k = 4; k <= 11; k++) expect_at(k, 7'b0000000, 7'b0000111, "rev_dead");
    expect_at(12, 7'b0010001, 7'b0011011, "rev_new_dir");
    expect_win(20, 2, 2, 7, "rev_ramp_restart");
    expect_win(100, 2, 1, 8, "rev_duty8");
    tick(120);

    // fault pulse of 2 clocks while running
    oc = 1'b1;
    expect_at(3, 7'b0000000, 7'b1000000, "fault_pre");
    expect_at(4, 7'b1000000, 7'h7F, "fault_latch");
    expect_at(30, 7'b1000000, 7'h7F, "fault_hold_en");
    tick(2);
    oc = 1'b0;
    tick(38);
    en = 1'b0;
    expect_at(3, 7'b1000000, 7'b1000000, "fault_exit_pre");
    expect_at(4, 7'b0000000, 7'h7F, "fault_clear");
    tick(10);
    en = 1'b1;
    expect_at(3, 7'b0000000, 7'b0011011, "restart_pre");
    expect_at(4, 7'b0010001, 7'b0011011, "restart_pins");
    expect_win(5, 2, 2, 5, "restart_ramp0");
    tick(30);

    // fault with sensor held high and enable low
    oc = 1'b1;
    expect_at(4, 7'b1000000, 7'h7F, "held_enter");
    tick(5);
    en = 1'b0;
    expect_at(20, 7'b1000000, 7'h7F, "held_stays");
    tick(25);
    oc = 1'b0;
    expect_at(6, 7'b0000000, 7'h7F, "held_clear");
    tick(10);

    // boundary duties
    dl = 1'b1; duty = 4'd0; en = 1'b1;
    expect_win(40, 2, 1, 0, "duty0");
    tick(60);
    duty = 4'd15;
    expect_win(120, 2, 1, 15, "duty15_left");
    expect_win(140, 5, 1, 15, "duty15_right");
    tick(160);
    duty = 4'd3;
    expect_win(20, 2, 3, 5, "ramp_down_mid");
    expect_win(100, 2, 1, 3, "duty3");
    tick(120);

    // async reset during dead time
    duty = 4'd8;
    tick(80);
    dl = 1'b0;
    tick(5);
    rst = 1'b1;
    expect_at(0, 7'b0000000, 7'h7F, "async_reset");
    tick(3);
    rst = 1'b0;
    expect_at(0, 7'b0000000, 7'h7F, "post_reset_zero");
    expect_at(3, 7'b0000000, 7'b0011011, "post_reset_idle");
    expect_at(4, 7'b0010001, 7'b0011011, "post_reset_drive");
    tick(10);

    for (int k = 0; k < 400 && sb.size() > 0; k++) tick(1);
    while (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %0s: never checked, required cycle %0d, now %0d", sb[0].nm, sb[0].stamp, cyc);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_pwm_drive.md
# motor_pwm_drive

Two-channel H-bridge motor drive for the delivery rover. Generates left/right PWM and direction pins from a duty target and direction switches, with soft-start ramping and dead-time coasting on reversal. It consumes the overcurrent stop from the current limiter and holds both motors off in a latched fault state until the operator clears it.

## Interface
- PWM_BITS, 8: PWM counter width. Period is 2^PWM_BITS clocks: 256 clocks, 390.6 kHz at 100 MHz.
- RAMP_DIV, 4096: clocks per one-LSB duty step.
- DEADTIME, 1024: coast clocks inserted on a direction reversal.

- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high. Clears all state.
- overcurrent_stop  in  1  stop request from the current limiter. Asynchronous to drive logic.
- enable  in  1  operator run switch. Asynchronous.
- dir_left, dir_right  in  1 each  direction switch (1 = forward). Asynchronous.
- duty_target  in  PWM_BITS  requested duty, shared by both channels. Quasi-static.
- pwm_left, pwm_right  out  1 each  H-bridge enable PWM.
- in1_left, in2_left, in1_right, in2_right  out  1 each  bridge direction pins.
  - Forward drives in1=1, in2=0.
  - Reverse drives in1=0, in2=1.
  - Coast drives in1=0, in2=0.
  - in1=in2=1 is never driven.
- fault  out  1  latched overcurrent indication, for the LED.

## Operation
- Input synchronization:
  - overcurrent_stop, enable, dir_left and dir_right each pass a 2-flop synchronizer.
  - All logic below uses the synchronized values.
- PWM counter:
  - cnt is free-running from 0 to 2^PWM_BITS-1, then wraps to 0.
  - Per channel, pwm = registered (cnt < cmp).
  - duty 0 gives constant low; the maximum duty gives (2^PWM_BITS-1)/2^PWM_BITS high.
- Compare loading: cmp loads duty_cur only on the cycle cnt = 2^PWM_BITS-1. A new duty therefore starts cleanly at cnt = 0.
- Ramp tick:
  - A shared divider produces a 1-cycle tick every RAMP_DIV clocks.
  - On each tick, a DRIVE channel moves duty_cur one LSB toward duty_target (up or down).
  - duty_cur never overshoots the target.
- Per-channel FSM, states IDLE, DRIVE, DEAD, FAULT:
  - IDLE:
    - duty_cur=0, pwm=0, coast.
    - Goes to DRIVE when enable=1, latching dir_applied=dir.
  - DRIVE:
    - Bridge pins follow dir_applied.
    - Goes to IDLE when enable=0: duty_cur=0 and pwm low next cycle.
    - Goes to DEAD when dir≠dir_applied.
  - DEAD:
    - duty_cur=0, pwm forced low immediately, coast.
    - The dead counter counts DEADTIME clocks, then latches dir_applied=dir and goes to DRIVE, ramping from 0.
    - If dir toggles back during DEAD, the count is not restarted.
    - enable=0 during DEAD goes to IDLE.
  - FAULT:
    - Entered from any state on overcurrent_stop=1.
    - pwm=0, coast, duty_cur=0.
    - The fault register is set. Both channels enter together.
- Fault exit:
  - Requires overcurrent_stop=0 and enable=0 simultaneously; both channels then go to IDLE and fault clears.
  - Restart is a further enable 0→1.
  - overcurrent_stop=1 with enable=0 stays in FAULT.
- Priority: reset > fault > enable=0 > direction change > ramp.
- Forced-low rule: pwm is forced low in IDLE, DEAD and FAULT regardless of cmp. cmp is reloaded to 0 at the next wrap.

## Timing
- Reset values:
  - All pwm and in* outputs 0, fault=0.
  - cnt, cmp, duty_cur and both divider counters 0; both FSMs IDLE.
- Fault latency: overcurrent_stop first sampled high at edge N gives pwm=0, coast pins and fault=1 after edge N+3. Breakdown: 2 synchronizer flops, then the FSM and output register.
- Enable latency: enable rise to DRIVE takes 3 edges.
- Duty latency: a duty_cur change appears on pwm in the period after the next wrap, up to 2^PWM_BITS+1 clocks.
- Ramp timing: a full ramp from 0 to target T takes T×RAMP_DIV clocks, ±RAMP_DIV.
- Reversal timing: a reversal produces exactly DEADTIME coast cycles between the last old-direction pin state and the first new-direction pin state.
- Reset mid-operation: asserting reset mid-ramp or mid-dead-time clears everything asynchronously. pwm is low within the reset assertion delta.

## Test plan
Use simulation parameters PWM_BITS=4, RAMP_DIV=4, DEADTIME=8.
- Soft start: reset, then enable=1, dir_left=1, duty_target=8 → in1_left=1/in2_left=0 after 3 edges. duty_cur reaches 8 after about 32 clocks. pwm_left is then high for 8 of every 16 clocks. No glitch mid-period.
- Reversal: while running at duty 8, toggle dir_left=0 → pwm_left low within 3 clocks and pins 00 for exactly 8 clocks. Then in2_left=1 and the ramp restarts from 0.
- Fault latch: overcurrent_stop pulsed high for 2 clocks while running → after edge N+3 both pwm=0, pins 00, fault=1. Fault stays set with enable=1. enable=0 clears it to IDLE. enable=1 ramps from 0.
- Fault with sensor held: overcurrent_stop held high and enable=0 → remains FAULT and fault=1.
- Boundary duties: duty_target=0 → pwm constant low. duty_target=15 → high 15 of every 16 clocks. Target lowered 15→3 ramps down one LSB per tick.
- Async reset: assert reset during DEAD → all outputs 0 immediately. After release the block is in IDLE, and enable must be sampled again before driving.
